// File: rtl/signed_bcd_encoder.sv
// signed_bcd_encoder
//   Converts a two's-complement operand into a sign flag G plus unsigned BCD
//   magnitude digits, using a multi-cycle double-dabble (shift/add-3) sequence
//   with a start/busy/done handshake. Feeds the minus-sign generator (G) and
//   the seven-segment digit mux (digits, blank).
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : conversion request, sampled only while idle
//   value  : signed operand, sampled with start
//   busy   : high whenever a conversion is in flight (including the done cycle)
//   done   : one-cycle pulse when G/digits/blank are updated
//   G      : 1 = result negative (nonzero negative input only)
//   digits : BCD magnitude, digit i at [4i+3:4i], digit 0 is least significant
//   blank  : bit i set when digit i is a leading zero; bit 0 always clear
module signed_bcd_encoder #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  G,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FIN
    } state_t;

    state_t                state, state_nx;
    logic [4*DIGITS-1:0]   bcd, adj, bcd_n;
    logic [WIDTH-1:0]      mag, mag_n;
    logic [CW-1:0]         cnt;
    logic                  sign;
    logic [DIGITS-1:0]     blank_n;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // One double-dabble step: add 3 to every nibble >= 5, then shift the
    // magnitude MSB into the BCD LSB. The BCD MSB falls off the top; with
    // 10^DIGITS > 2^(WIDTH-1) it is always zero for a legal result.
    always_comb begin
        adj = bcd;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        {bcd_n, mag_n} = {adj, mag} << 1;
    end

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        blank_n = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            blank_n[i] = ((bcd_n >> (4*i)) == '0);
        end
    end

    // Datapath; outputs only change on the final iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd    <= '0;
            mag    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            G      <= 1'b0;
            digits <= '0;
            blank  <= BLANK_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign <= value[WIDTH-1];
                        // Unsigned negate: the most negative value maps to 2^(WIDTH-1).
                        mag  <= value[WIDTH-1] ? (~value + 1'b1) : value;
                        bcd  <= '0;
                        cnt  <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bcd <= bcd_n;
                    mag <= mag_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        digits <= bcd_n;
                        G      <= sign;
                        blank  <= blank_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_bcd_encoder.sv
module tb_signed_bcd_encoder;

    localparam int W = 8;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   value;
    logic           busy, done, G;
    logic [4*D-1:0] digits;
    logic [D-1:0]   blank;

    int errors = 0;
    int checks = 0;

    signed_bcd_encoder #(.WIDTH(W), .DIGITS(D)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .busy(busy), .done(done), .G(G), .digits(digits), .blank(blank)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal magnitude by plain arithmetic.
    function automatic void model(input logic [7:0] v, output logic g,
                                  output logic [11:0] d, output logic [2:0] b);
        int sv, m;
        sv = int'($signed(v));
        m  = (sv < 0) ? -sv : sv;
        g  = (sv < 0);
        d  = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
        b  = {m < 100, m < 10, 1'b0};
    endfunction

    task automatic check_result(input logic [7:0] v, input string tag);
        logic g; logic [11:0] d; logic [2:0] b;
        model(v, g, d, b);
        chk({tag, ".G"}, 32'(G), 32'(g));
        chk({tag, ".digits"}, 32'(digits), 32'(d));
        chk({tag, ".blank"}, 32'(blank), 32'(b));
    endtask

    task automatic convert(input logic [7:0] v, input string tag);
        int n;
        @(negedge clk); start = 1'b1; value = v;
        @(posedge clk); #1;
        start = 1'b0;
        value = 8'($urandom);          // must not affect the result
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!done && n < 20);
        chk({tag, ".latency"}, 32'(n), 32'd8);
        check_result(v, tag);
        @(posedge clk); #1;
        chk({tag, ".donepulse"}, 32'(done), 32'd0);
    endtask

    logic [7:0] perm [256];
    logic [7:0] tmp;
    int         busyc, donec, n, last, j;
    logic [11:0] capd;

    initial begin
        rst = 1'b1; start = 1'b0; value = '0;
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.G", 32'(G), 32'd0);
        chk("rst.digits", 32'(digits), 32'h000);
        chk("rst.blank", 32'(blank), 32'b110);
        @(negedge clk); rst = 1'b0;

        convert(8'd0,   "zero");
        convert(8'hFF,  "m1");
        convert(8'h80,  "m128");
        convert(8'd127, "p127");
        convert(8'hF6,  "m10");
        for (int i = 0; i < 6; i++) convert(8'($urandom), "rand");

        // start while busy is ignored
        @(negedge clk); start = 1'b1; value = 8'd42;
        @(posedge clk); #1;
        busyc = busy ? 1 : 0; donec = 0; capd = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) begin start = 1'b1; value = 8'd99; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (busy) busyc++;
            if (done) begin donec++; capd = digits; end
        end
        start = 1'b0;
        chk("ign.donecount", 32'(donec), 32'd1);
        chk("ign.busycycles", 32'(busyc), 32'd9);
        chk("ign.digits", 32'(capd), 32'h042);

        // reset mid-conversion
        @(negedge clk); start = 1'b1; value = 8'h9C;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.G", 32'(G), 32'd0);
        chk("abort.digits", 32'(digits), 32'h000);
        chk("abort.blank", 32'(blank), 32'b110);
        @(negedge clk); rst = 1'b0;
        donec = 0;
        for (int k = 0; k < 12; k++) begin @(posedge clk); #1; if (done) donec++; end
        chk("abort.nodone", 32'(donec), 32'd0);
        convert(8'd7, "after");

        // full sweep, shuffled, back-to-back with start held high
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        @(negedge clk); start = 1'b1; value = perm[0];
        last = 0; n = 0;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!done && n < 30);
            chk("sweep.seen", 32'(done), 32'd1);
            if (i > 0) chk("sweep.spacing", 32'(n), 32'd10);
            check_result(perm[i], "sweep");
            if (i < 255) value = perm[i+1];
            else start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
